// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle for ifetch_queue: instruction-memory request/response,
// decode redirect/stall and the prefetch-queue head.
interface ifetch_queue_if #(
   parameter int unsigned AW    = 32,
   parameter int unsigned IW    = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_valid;
   logic          imem_abort;
   logic [IW-1:0] imem_rdata;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          stall;
   logic          instr_valid;
   logic [IW-1:0] instr;
   logic [AW-1:0] pc4;
   logic [CW-1:0] count;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, pc4, count,
      input  imem_valid, imem_abort, imem_rdata, redirect, redirect_pc, stall
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, pc4, count,
      output imem_valid, imem_abort, imem_rdata, redirect, redirect_pc, stall
   );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: one outstanding imem request with abort retry,
// a DEPTH-entry prefetch queue drained by decode, and redirect flush.
module ifetch_queue #(
   parameter int unsigned   AW       = 32,
   parameter int unsigned   IW       = 32,
   parameter int unsigned   DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input logic            clk,
   input logic            reset,
   ifetch_queue_if.master bus
);
   localparam int unsigned   PW      = $clog2(DEPTH);
   localparam int unsigned   CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] fpc_q, fpc_d;
   logic          req_q, req_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] count_after_pop;
   logic          push, pop, resp;

   logic [IW-1:0] instr_mem [DEPTH];
   logic [AW-1:0] pc4_mem   [DEPTH];

   assign pop             = (count_q != '0) && !bus.stall;
   assign resp            = bus.imem_valid || bus.imem_abort;
   assign count_after_pop = count_q - CW'(pop);

   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      req_d   = 1'b0;
      addr_d  = addr_q;
      push    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (count_after_pop < DEPTH_C) begin
               req_d   = 1'b1;
               addr_d  = fpc_q;
               state_d = StWait;
            end
         end
         StWait: begin
            if (bus.imem_valid) begin
               push  = 1'b1;
               fpc_d = fpc_q + AW'(4);
               // Chain the next request only if the pushed entry leaves room for it.
               if (count_after_pop + CW'(1) < DEPTH_C) begin
                  req_d  = 1'b1;
                  addr_d = fpc_q + AW'(4);
               end else begin
                  state_d = StIdle;
               end
            end else if (bus.imem_abort) begin
               req_d = 1'b1;
            end
         end
         StDrop: begin
            if (resp) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Redirect overrides everything; an unanswered request must be drained in StDrop.
      if (bus.redirect) begin
         push    = 1'b0;
         req_d   = 1'b0;
         addr_d  = addr_q;
         fpc_d   = bus.redirect_pc;
         state_d = ((state_q == StWait || state_q == StDrop) && !resp) ? StDrop : StIdle;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.redirect) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(pop);
         tail_d  = tail_q + PW'(push);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         fpc_q   <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !bus.redirect) begin
         instr_mem[tail_q] <= bus.imem_rdata;
         pc4_mem[tail_q]   <= addr_q + AW'(4);
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = addr_q;
   assign bus.instr_valid = (count_q != '0);
   assign bus.instr       = instr_mem[head_q];
   assign bus.pc4         = pc4_mem[head_q];
   assign bus.count       = count_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a small latency/abort memory model.
module tb_ifetch_queue;
   localparam int unsigned AW    = 32;
   localparam int unsigned IW    = 32;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic reset;

   ifetch_queue_if #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) bus ();

   ifetch_queue #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int            mem_lat;
   int            pend_cnt;
   logic [AW-1:0] pend_addr;
   logic [AW-1:0] abort_addr;
   int            abort_n;
   int            req_at_abort;
   logic [AW-1:0] got_pc4[$];
   logic [IW-1:0] got_instr[$];

   function automatic logic [IW-1:0] mdata(input logic [AW-1:0] a);
      return IW'(a) ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Records pops, advances one clock, then plays the memory for this cycle.
   task automatic tick();
      if (bus.instr_valid && !bus.stall && !bus.redirect && !reset) begin
         got_pc4.push_back(bus.pc4);
         got_instr.push_back(bus.instr);
      end
      @(posedge clk);
      #1;
      bus.imem_valid = 1'b0;
      bus.imem_abort = 1'b0;
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            if (abort_n > 0 && pend_addr == abort_addr) begin
               bus.imem_abort = 1'b1;
               abort_n--;
            end else begin
               bus.imem_valid = 1'b1;
               bus.imem_rdata = mdata(pend_addr);
            end
         end
      end
      if (bus.imem_req) begin
         if (bus.imem_addr == abort_addr) req_at_abort++;
         if (mem_lat > 0) begin
            pend_cnt  = mem_lat;
            pend_addr = bus.imem_addr;
         end
      end
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      pend_cnt       = 0;
      bus.imem_valid = 1'b0;
      bus.imem_abort = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int t;
      int reqs;
      reset           = 1'b1;
      bus.imem_valid  = 1'b0;
      bus.imem_abort  = 1'b0;
      bus.imem_rdata  = '0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.stall       = 1'b0;
      mem_lat         = 1;
      pend_cnt        = 0;
      pend_addr       = '0;
      abort_addr      = '1;
      abort_n         = 0;
      req_at_abort    = 0;
      #1;
      check("rst_req", 64'(bus.imem_req), 64'(0));
      check("rst_addr", 64'(bus.imem_addr), 64'(0));
      check("rst_count", 64'(bus.count), 64'(0));
      check("rst_ivalid", 64'(bus.instr_valid), 64'(0));

      // Basic stream, no stall.
      do_reset();
      tick();
      check("c1_req", 64'(bus.imem_req), 64'(1));
      check("c1_addr", 64'(bus.imem_addr), 64'(0));
      tick();
      check("c2_ivalid", 64'(bus.instr_valid), 64'(0));
      tick();
      check("c3_ivalid", 64'(bus.instr_valid), 64'(1));
      check("c3_pc4", 64'(bus.pc4), 64'(4));
      check("c3_instr", 64'(bus.instr), 64'(mdata(32'h0)));
      check("c3_addr", 64'(bus.imem_addr), 64'(4));
      repeat (8) tick();
      check("stream_pops", 64'(got_pc4.size()), 64'(4));
      for (int i = 0; i < got_pc4.size(); i++) begin
         check("stream_pc4", 64'(got_pc4[i]), 64'(4 * (i + 1)));
         check("stream_instr", 64'(got_instr[i]), 64'(mdata(AW'(4 * i))));
      end

      // Stall until full, then drain.
      got_pc4.delete();
      got_instr.delete();
      bus.stall = 1'b1;
      repeat (12) tick();
      check("full_count", 64'(bus.count), 64'(DEPTH));
      check("full_head_pc4", 64'(bus.pc4), 64'(20));
      reqs = 0;
      repeat (4) begin
         tick();
         if (bus.imem_req) reqs++;
      end
      check("full_no_req", 64'(reqs), 64'(0));
      bus.stall = 1'b0;
      repeat (16) tick();
      check("drain_enough", 64'(got_pc4.size() >= 6), 64'(1));
      for (int i = 0; i < got_pc4.size(); i++) begin
         check("drain_pc4", 64'(got_pc4[i]), 64'(20 + 4 * i));
         check("drain_instr", 64'(got_instr[i]), 64'(mdata(AW'(16 + 4 * i))));
      end

      // Two aborts on 0x8, then success.
      abort_addr   = 32'h8;
      abort_n      = 2;
      req_at_abort = 0;
      bus.stall    = 1'b1;
      do_reset();
      got_pc4.delete();
      got_instr.delete();
      repeat (14) tick();
      check("abort_reqs", 64'(req_at_abort), 64'(3));
      check("abort_count", 64'(bus.count), 64'(DEPTH));
      bus.stall = 1'b0;
      repeat (6) tick();
      check("abort_pops", 64'(got_pc4.size() >= 4), 64'(1));
      for (int i = 0; i < 4; i++) begin
         check("abort_pc4", 64'(got_pc4[i]), 64'(4 * (i + 1)));
         check("abort_instr", 64'(got_instr[i]), 64'(mdata(AW'(4 * i))));
      end
      abort_n    = 0;
      abort_addr = '1;

      // Redirect with a request outstanding; its late response must be discarded.
      mem_lat = 2;
      t = 0;
      while (!bus.imem_req && t < 20) begin
         tick();
         t++;
      end
      check("rd_req_seen", 64'(bus.imem_req), 64'(1));
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h100;
      tick();
      bus.redirect = 1'b0;
      mem_lat      = 1;
      check("rd_count", 64'(bus.count), 64'(0));
      check("rd_ivalid", 64'(bus.instr_valid), 64'(0));
      check("rd_drop_noreq", 64'(bus.imem_req), 64'(0));
      tick();
      tick();
      check("rd_dropped", 64'(bus.count), 64'(0));
      t = 0;
      while (!bus.imem_req && t < 20) begin
         tick();
         t++;
      end
      check("rd_new_addr", 64'(bus.imem_addr), 64'(32'h100));
      t = 0;
      while (!bus.instr_valid && t < 20) begin
         tick();
         t++;
      end
      check("rd_pc4", 64'(bus.pc4), 64'(32'h104));
      check("rd_instr", 64'(bus.instr), 64'(mdata(32'h100)));

      // Redirect coinciding with a push and a pop at count=2.
      bus.stall = 1'b1;
      t = 0;
      while (!(bus.count == 2 && bus.imem_valid) && t < 30) begin
         tick();
         t++;
      end
      check("rp_setup", 64'(bus.count == 2 && bus.imem_valid), 64'(1));
      bus.stall       = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h200;
      tick();
      bus.redirect = 1'b0;
      check("rp_count", 64'(bus.count), 64'(0));
      check("rp_ivalid", 64'(bus.instr_valid), 64'(0));
      t = 0;
      while (!bus.imem_req && t < 20) begin
         tick();
         t++;
      end
      check("rp_new_addr", 64'(bus.imem_addr), 64'(32'h200));
      t = 0;
      while (!bus.instr_valid && t < 20) begin
         tick();
         t++;
      end
      check("rp_pc4", 64'(bus.pc4), 64'(32'h204));

      // Asynchronous reset mid-WAIT with three entries queued.
      bus.stall = 1'b1;
      t = 0;
      while (bus.count != 3 && t < 30) begin
         tick();
         t++;
      end
      check("ar_setup", 64'(bus.count), 64'(3));
      #2;
      reset = 1'b1;
      #1;
      check("ar_req", 64'(bus.imem_req), 64'(0));
      check("ar_addr", 64'(bus.imem_addr), 64'(0));
      check("ar_count", 64'(bus.count), 64'(0));
      check("ar_ivalid", 64'(bus.instr_valid), 64'(0));
      pend_cnt       = 0;
      bus.imem_valid = 1'b0;
      bus.imem_abort = 1'b0;
      bus.stall      = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      check("ar_first_req", 64'(bus.imem_req), 64'(1));
      check("ar_first_addr", 64'(bus.imem_addr), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
